// File: rtl/nano_miss_arbiter.sv
// nano_miss_arbiter: sequences PE misses and writebacks onto one line-wide memory port.
// Optional read watchdog enabled by defining NANO_ARB_TIMEOUT_EN.
module nano_miss_arbiter #(
  parameter int NUM_PE      = 4,
  parameter int LINE_WORDS  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [NUM_PE-1:0]                    i_miss_rden,
  input  logic [NUM_PE-1:0]                    i_miss_wren,
  input  logic [NUM_PE-1:0][31:0]              i_miss_addr,
  input  logic [NUM_PE-1:0][LINE_WORDS-1:0][31:0] i_miss_wdata,
  output logic [NUM_PE-1:0]                    o_miss_resp,
  input  logic [NUM_PE-1:0]                    i_wb_wren,
  input  logic [NUM_PE-1:0][31:0]              i_wb_addr,
  input  logic [NUM_PE-1:0][LINE_WORDS-1:0][31:0] i_wb_wdata,
  output logic [NUM_PE-1:0]                    o_wb_gnt,
  output logic                                 o_mm_rden,
  output logic                                 o_mm_wren,
  output logic [31:0]                          o_mm_addr,
  output logic [LINE_WORDS-1:0][31:0]          o_mm_wdata,
  input  logic                                 i_mm_gnt,
  input  logic [LINE_WORDS-1:0][31:0]          i_mm_rdata,
  input  logic                                 i_mm_rvalid,
  output logic [NUM_PE-1:0]                    o_upd_valid,
  output logic [LINE_WORDS-1:0][31:0]          o_upd_rdata,
  output logic                                 o_busy,
  output logic                                 o_timeout
);

  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  if (NUM_PE < 1 || NUM_PE > 8 || TIMEOUT_CYC < 1) begin : g_param_err
    $error("nano_miss_arbiter: bad parameter");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD
  } state_t;

  typedef enum logic [1:0] {
    K_RD,
    K_WR,
    K_WB
  } kind_t;

  state_t          state;
  state_t          state_nx;
  kind_t           kind;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;

  logic [NUM_PE-1:0] miss_req;
  logic            miss_any;
  logic            wb_any;
  logic            found;
  logic [PW-1:0]   miss_idx;
  logic [PW-1:0]   wb_idx;
  logic [PW-1:0]   rr_nx;
  logic [PW-1:0]   scan;
  int              pos;

  logic            take_miss;
  logic            take_wb;
  logic            gnt_done;
  logic            rd_done;

  // Round-robin scan starting at the pointer; writebacks use fixed priority.
  always_comb begin
    miss_req = i_miss_rden | i_miss_wren;
    miss_any = |miss_req;
    wb_any   = |i_wb_wren;
    found    = 1'b0;
    miss_idx = '0;
    wb_idx   = '0;
    scan     = '0;
    pos      = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      pos = int'(rr_ptr) + i;
      if (pos >= NUM_PE) pos = pos - NUM_PE;
      scan = PW'(pos);
      if (!found && miss_req[scan]) begin
        found    = 1'b1;
        miss_idx = scan;
      end
    end
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      if (i_wb_wren[PW'(i)]) wb_idx = PW'(i);
    end
    rr_nx = (miss_idx == PW'(NUM_PE - 1)) ? '0 : miss_idx + 1'b1;
  end

`ifdef NANO_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                      $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
`endif

  always_comb begin
    state_nx  = state;
    take_miss = 1'b0;
    take_wb   = 1'b0;
    gnt_done  = 1'b0;
    rd_done   = 1'b0;
`ifdef NANO_ARB_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (miss_any) begin
          take_miss = 1'b1;
          state_nx  = S_REQ;
        end else if (wb_any) begin
          take_wb  = 1'b1;
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (i_mm_gnt) begin
          gnt_done = 1'b1;
          state_nx = (kind == K_RD) ? S_WAIT_RD : S_IDLE;
        end
      end
      S_WAIT_RD: begin
        if (i_mm_rvalid) begin
          rd_done  = 1'b1;
          state_nx = S_IDLE;
        end
`ifdef NANO_ARB_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          to_hit   = 1'b1;
          state_nx = S_IDLE;
        end
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      kind        <= K_RD;
      rr_ptr      <= '0;
      win         <= '0;
      o_mm_rden   <= 1'b0;
      o_mm_wren   <= 1'b0;
      o_mm_addr   <= '0;
      o_mm_wdata  <= '0;
      o_miss_resp <= '0;
      o_wb_gnt    <= '0;
      o_upd_valid <= '0;
      o_upd_rdata <= '0;
    end else begin
      state       <= state_nx;
      o_miss_resp <= '0;
      o_wb_gnt    <= '0;
      o_upd_valid <= '0;
      if (take_miss) begin
        win        <= miss_idx;
        rr_ptr     <= rr_nx;
        kind       <= i_miss_wren[miss_idx] ? K_WR : K_RD;
        o_mm_rden  <= ~i_miss_wren[miss_idx];
        o_mm_wren  <= i_miss_wren[miss_idx];
        o_mm_addr  <= i_miss_addr[miss_idx];
        o_mm_wdata <= i_miss_wdata[miss_idx];
      end
      if (take_wb) begin
        win        <= wb_idx;
        kind       <= K_WB;
        o_mm_rden  <= 1'b0;
        o_mm_wren  <= 1'b1;
        o_mm_addr  <= i_wb_addr[wb_idx];
        o_mm_wdata <= i_wb_wdata[wb_idx];
      end
      if (gnt_done) begin
        o_mm_rden <= 1'b0;
        o_mm_wren <= 1'b0;
        if (kind == K_WB) o_wb_gnt[win] <= 1'b1;
        else              o_miss_resp[win] <= 1'b1;
      end
      if (rd_done) begin
        o_upd_rdata      <= i_mm_rdata;
        o_upd_valid[win] <= 1'b1;
      end
    end
  end

`ifdef NANO_ARB_TIMEOUT_EN
  // Counter sits at zero outside WAIT_RD, so it restarts on every entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= to_hit;
      if (state != S_WAIT_RD) to_cnt <= '0;
      else if (!i_mm_rvalid)  to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_nano_miss_arbiter.sv
// tb_nano_miss_arbiter: vector table plus hand sequences, scoreboarded issue/refill checks.
// Build with NANO_ARB_TIMEOUT_EN to exercise the read watchdog.
module tb_nano_miss_arbiter;

  localparam int NP = 4;
  localparam int LW = 8;
  localparam int TO = 16;

  typedef logic [LW-1:0][31:0] line_t;
  typedef enum logic [1:0] {K_RD, K_WR, K_WB} kind_e;

  typedef struct {
    kind_e          kind;
    int             pe;
    logic [31:0]    addr;
    line_t          data;
    logic [NP-1:0]  resp;
    logic [NP-1:0]  wbg;
  } iss_t;

  typedef struct {
    logic [NP-1:0]  vld;
    line_t          data;
  } upd_t;

  typedef struct {
    int             pe;
    kind_e          kind;
    logic [31:0]    addr;
    int             gdly;
    int             rdly;
    int             exp_hi;
    logic [NP-1:0]  exp_resp;
    logic [NP-1:0]  exp_wbg;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NP-1:0]             miss_rden;
  logic [NP-1:0]             miss_wren;
  logic [NP-1:0][31:0]       miss_addr;
  logic [NP-1:0][LW-1:0][31:0] miss_wdata;
  logic [NP-1:0]             o_miss_resp;
  logic [NP-1:0]             wb_wren;
  logic [NP-1:0][31:0]       wb_addr;
  logic [NP-1:0][LW-1:0][31:0] wb_wdata;
  logic [NP-1:0]             o_wb_gnt;
  logic                      o_mm_rden;
  logic                      o_mm_wren;
  logic [31:0]               o_mm_addr;
  line_t                     o_mm_wdata;
  logic                      mm_gnt;
  line_t                     mm_rdata;
  logic                      mm_rvalid;
  logic [NP-1:0]             o_upd_valid;
  line_t                     o_upd_rdata;
  logic                      o_busy;
  logic                      o_timeout;

  int   n_chk = 0;
  int   n_err = 0;
  iss_t iss_q[$];
  upd_t upd_q[$];
  vec_t vecs[8];

  nano_miss_arbiter #(
    .NUM_PE(NP),
    .LINE_WORDS(LW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_miss_rden(miss_rden),
    .i_miss_wren(miss_wren),
    .i_miss_addr(miss_addr),
    .i_miss_wdata(miss_wdata),
    .o_miss_resp(o_miss_resp),
    .i_wb_wren(wb_wren),
    .i_wb_addr(wb_addr),
    .i_wb_wdata(wb_wdata),
    .o_wb_gnt(o_wb_gnt),
    .o_mm_rden(o_mm_rden),
    .o_mm_wren(o_mm_wren),
    .o_mm_addr(o_mm_addr),
    .o_mm_wdata(o_mm_wdata),
    .i_mm_gnt(mm_gnt),
    .i_mm_rdata(mm_rdata),
    .i_mm_rvalid(mm_rvalid),
    .o_upd_valid(o_upd_valid),
    .o_upd_rdata(o_upd_rdata),
    .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  function automatic line_t pat(input logic [31:0] s);
    line_t l;
    for (int k = 0; k < LW; k++) l[k] = s + 32'(k) * 32'h0101_0101;
    return l;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: expected event did not occur as required", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {o_mm_rden, o_mm_wren, o_busy, o_timeout,
                        o_miss_resp, o_wb_gnt, o_upd_valid}, '0);
    chk({tag, "_addr"}, o_mm_addr, '0);
    chk({tag, "_wdata"}, o_mm_wdata, '0);
    chk({tag, "_rdata"}, o_upd_rdata, '0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_mm_rden || o_mm_wren) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("wait_req");
  endtask

  task automatic push_iss(input kind_e k, input int pe, input logic [31:0] a,
                          input line_t d, input logic [NP-1:0] r,
                          input logic [NP-1:0] w);
    iss_t e;
    e.kind = k;
    e.pe   = pe;
    e.addr = a;
    e.data = d;
    e.resp = r;
    e.wbg  = w;
    iss_q.push_back(e);
  endtask

  task automatic push_upd(input logic [NP-1:0] v, input line_t d);
    upd_t u;
    u.vld  = v;
    u.data = d;
    upd_q.push_back(u);
  endtask

  // Leaves the DUT in the first WAIT_RD cycle with the request dropped.
  task automatic start_read(input int pe, input logic [31:0] a);
    bit ok;
    push_iss(K_RD, pe, a, '0, NP'(1 << pe), '0);
    miss_addr[pe] = a;
    miss_rden[pe] = 1'b1;
    wait_req(ok);
    mm_gnt = 1'b1;
    tick();
    mm_gnt = 1'b0;
    miss_rden[pe] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    line_t d;
    bit    ok;
    int    hi;
    d = pat(v.addr ^ 32'h5A5A_0000);
    push_iss(v.kind, v.pe, v.addr, d, v.exp_resp, v.exp_wbg);
    case (v.kind)
      K_RD: begin
        miss_addr[v.pe] = v.addr;
        miss_rden[v.pe] = 1'b1;
      end
      K_WR: begin
        miss_addr[v.pe]  = v.addr;
        miss_wdata[v.pe] = d;
        miss_wren[v.pe]  = 1'b1;
      end
      default: begin
        wb_addr[v.pe]  = v.addr;
        wb_wdata[v.pe] = d;
        wb_wren[v.pe]  = 1'b1;
      end
    endcase
    wait_req(ok);
    hi = 1;
    for (int k = 0; k < v.gdly; k++) begin
      tick();
      if (o_mm_rden || o_mm_wren) hi++;
    end
    mm_gnt = 1'b1;
    tick();
    mm_gnt = 1'b0;
    miss_rden = '0;
    miss_wren = '0;
    wb_wren = '0;
    chk("mm_req_cycles", hi, v.exp_hi);
    chk("mm_req_drop", {o_mm_rden, o_mm_wren}, '0);
    if (v.kind == K_RD) begin
      chk("busy_wait_rd", o_busy, 1'b1);
      for (int k = 0; k < v.rdly; k++) tick();
      mm_rdata = pat(v.addr ^ 32'hA5A5_A5A5);
      mm_rvalid = 1'b1;
      push_upd(v.exp_resp, mm_rdata);
      tick();
      mm_rvalid = 1'b0;
    end
    tick();
    chk("busy_after", o_busy, 1'b0);
    chk("upd_drained", upd_q.size(), 0);
    chk("iss_drained", iss_q.size(), 0);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from input updates.
  initial begin
    iss_t          e;
    upd_t          u;
    bit            pend;
    logic [NP-1:0] pr;
    logic [NP-1:0] pw;
    pend = 1'b0;
    pr = '0;
    pw = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("resp_pulse", o_miss_resp, pr);
          chk("wbgnt_pulse", o_wb_gnt, pw);
          pend = 1'b0;
        end else if (o_miss_resp != '0 || o_wb_gnt != '0) begin
          fail("stray_pulse");
        end
        if (mm_gnt && (o_mm_rden || o_mm_wren)) begin
          if (iss_q.size() == 0) begin
            fail("issue_unexpected");
          end else begin
            e = iss_q.pop_front();
            chk("issue_rd", o_mm_rden, e.kind == K_RD);
            chk("issue_wr", o_mm_wren, e.kind != K_RD);
            chk("issue_addr", o_mm_addr, e.addr);
            if (e.kind != K_RD) chk("issue_wdata", o_mm_wdata, e.data);
            pr = e.resp;
            pw = e.wbg;
            pend = 1'b1;
          end
        end
        if (o_upd_valid != '0) begin
          if (upd_q.size() == 0) begin
            fail("upd_unexpected");
          end else begin
            u = upd_q.pop_front();
            chk("upd_valid", o_upd_valid, u.vld);
            chk("upd_rdata", o_upd_rdata, u.data);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    fail("global_watchdog");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int  order[5];
    bit  got;
    int  n;
    vecs[0] = '{1, K_RD, 32'h0000_1000, 2, 4, 3, 4'b0010, 4'b0000};
    vecs[1] = '{0, K_WR, 32'h0000_2000, 0, 0, 1, 4'b0001, 4'b0000};
    vecs[2] = '{3, K_WB, 32'h0000_3040, 1, 0, 2, 4'b0000, 4'b1000};
    vecs[3] = '{2, K_RD, 32'h0000_4080, 0, 0, 1, 4'b0100, 4'b0000};
    vecs[4] = '{3, K_WR, 32'hFFFF_FFC0, 3, 0, 4, 4'b1000, 4'b0000};
    vecs[5] = '{0, K_WB, 32'h0000_0000, 0, 0, 1, 4'b0000, 4'b0001};
    vecs[6] = '{2, K_WR, 32'h0000_5000, 1, 0, 2, 4'b0100, 4'b0000};
    vecs[7] = '{1, K_RD, 32'h0000_6000, 1, 2, 2, 4'b0010, 4'b0000};
    order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    miss_rden = '0;
    miss_wren = '0;
    miss_addr = '0;
    miss_wdata = '0;
    wb_wren = '0;
    wb_addr = '0;
    wb_wdata = '0;
    mm_gnt = 1'b0;
    mm_rdata = '0;
    mm_rvalid = 1'b0;
    do_reset();
    chk_reset("rst_init");

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Miss write beats a writeback raised in the same cycle.
    miss_addr[3] = 32'h0000_7000;
    miss_wdata[3] = pat(32'h7000_0000);
    wb_addr[2] = 32'h0000_7100;
    wb_wdata[2] = pat(32'h7100_0000);
    push_iss(K_WR, 3, 32'h0000_7000, pat(32'h7000_0000), 4'b1000, 4'b0000);
    push_iss(K_WB, 2, 32'h0000_7100, pat(32'h7100_0000), 4'b0000, 4'b0100);
    miss_wren[3] = 1'b1;
    wb_wren[2] = 1'b1;
    mm_gnt = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_miss_resp[3]) miss_wren[3] = 1'b0;
      if (o_wb_gnt[2]) begin
        wb_wren[2] = 1'b0;
        got = 1'b1;
        break;
      end
    end
    if (!got) fail("prio_seq");
    mm_gnt = 1'b0;
    tick();
    chk("prio_busy", o_busy, 1'b0);
    chk("prio_drained", iss_q.size(), 0);

    // Round robin with all PEs reading continuously.
    do_reset();
    for (int p = 0; p < NP; p++) miss_addr[p] = 32'h0000_8000 + 32'(p * 64);
    for (int i = 0; i < 5; i++)
      push_iss(K_RD, order[i], 32'h0000_8000 + 32'(order[i] * 64), '0,
               NP'(1 << order[i]), '0);
    mm_gnt = 1'b1;
    miss_rden = '1;
    for (int i = 0; i < 5; i++) begin
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (o_miss_resp != '0) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) fail("rr_resp");
      mm_rdata = pat(32'hC0DE_0000 + 32'(i));
      mm_rvalid = 1'b1;
      if (i == 4) miss_rden = '0;
      push_upd(NP'(1 << order[i]), mm_rdata);
      tick();
      mm_rvalid = 1'b0;
    end
    mm_gnt = 1'b0;
    tick();
    tick();
    chk("rr_busy", o_busy, 1'b0);
    chk("rr_iss_drained", iss_q.size(), 0);
    chk("rr_upd_drained", upd_q.size(), 0);

    // Stray rvalid in IDLE and stray gnt in WAIT_RD.
    mm_rvalid = 1'b1;
    tick();
    tick();
    mm_rvalid = 1'b0;
    chk("stray_rv_upd", o_upd_valid, '0);
    chk("stray_rv_busy", o_busy, 1'b0);
    start_read(0, 32'h0000_9000);
    mm_gnt = 1'b1;
    tick();
    tick();
    tick();
    mm_gnt = 1'b0;
    chk("stray_gnt_busy", o_busy, 1'b1);
    chk("stray_gnt_req", {o_mm_rden, o_mm_wren}, '0);
    chk("stray_gnt_upd", o_upd_valid, '0);
    mm_rdata = pat(32'h9999_0000);
    mm_rvalid = 1'b1;
    push_upd(4'b0001, mm_rdata);
    tick();
    mm_rvalid = 1'b0;
    tick();
    chk("stray_done_busy", o_busy, 1'b0);
    chk("stray_upd_drained", upd_q.size(), 0);

    // Reset while waiting for read data; the late rvalid must be dropped.
    start_read(1, 32'h0000_A000);
    tick();
    rst = 1'b1;
    tick();
    chk_reset("rst_mid");
    rst = 1'b0;
    mm_rdata = pat(32'hDEAD_0000);
    mm_rvalid = 1'b1;
    tick();
    mm_rvalid = 1'b0;
    chk("rst_late_upd", o_upd_valid, '0);
    tick();
    chk("rst_late_upd2", o_upd_valid, '0);
    chk("rst_late_busy", o_busy, 1'b0);

    // Read granted but data never arrives.
    start_read(2, 32'h0000_B000);
`ifdef NANO_ARB_TIMEOUT_EN
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      n++;
      if (o_timeout) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail("timeout_pulse");
    chk("timeout_cycles", n, TO);
    chk("timeout_busy", o_busy, 1'b0);
    chk("timeout_upd", o_upd_valid, '0);
    mm_rdata = pat(32'hBBBB_0000);
    mm_rvalid = 1'b1;
    tick();
    mm_rvalid = 1'b0;
    chk("timeout_one_cycle", o_timeout, 1'b0);
    tick();
    chk("timeout_late_upd", o_upd_valid, '0);
    chk("timeout_late_busy", o_busy, 1'b0);
`else
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_busy) n++;
    end
    chk("no_timeout_busy", n, 40);
    chk("no_timeout_pulse", o_timeout, 1'b0);
    mm_rdata = pat(32'hBBBB_0000);
    mm_rvalid = 1'b1;
    push_upd(4'b0100, mm_rdata);
    tick();
    mm_rvalid = 1'b0;
    tick();
    chk("no_timeout_done", o_busy, 1'b0);
    chk("no_timeout_drained", upd_q.size(), 0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
